// File: rtl/alu_seq_if.sv
// Purpose : request/response bundle between the control unit's EX state and
//           the multi-cycle ALU (alu_seq).
// Handshake: the master raises alu_en with alu_op/op_unsigned/op_a/op_b and
//           keeps alu_en high until it has seen the one-cycle alu_valid pulse.
//           The slave samples the request only from idle. alu_result and
//           alu_zero stay stable from alu_valid until the next accept.
//           Lowering alu_en before alu_valid abandons the request.
//           alu_busy is high from the accept edge until the slave is idle again.
// Signals : alu_en, alu_op[4:0], op_unsigned, op_a, op_b  (master -> slave)
//           alu_result, alu_valid, alu_busy, alu_zero     (slave -> master)
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             alu_en;
  logic [4:0]       alu_op;
  logic             op_unsigned;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] alu_result;
  logic             alu_valid;
  logic             alu_busy;
  logic             alu_zero;

  modport master (
    output alu_en, alu_op, op_unsigned, op_a, op_b,
    input  alu_result, alu_valid, alu_busy, alu_zero
  );

  modport slave (
    input  alu_en, alu_op, op_unsigned, op_a, op_b,
    output alu_result, alu_valid, alu_busy, alu_zero
  );
endinterface

// File: rtl/alu_seq.sv
// Purpose : multi-cycle integer ALU for the RV32I multi-cycle core. Fixed
//           two-edge latency for all ops except shifts, which move one bit
//           per cycle (latency 1+shamt edges).
// Ports   : clk          - clock, posedge
//           rst          - synchronous, active-high reset
//           bus          - alu_seq_if.slave request/response bundle
//           o_dbg_state  - current FSM state (0 IDLE, 1 EXEC, 2 SHIFT, 3 HOLD)
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  alu_seq_if.slave   bus,
  output logic [1:0] o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_SHIFT = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  localparam logic [4:0] OP_ADD   = 5'b00001;
  localparam logic [4:0] OP_SUB   = 5'b00011;
  localparam logic [4:0] OP_SLT   = 5'b00101;
  localparam logic [4:0] OP_AND   = 5'b01010;
  localparam logic [4:0] OP_OR    = 5'b01100;
  localparam logic [4:0] OP_XOR   = 5'b01101;
  localparam logic [4:0] OP_SLL   = 5'b01110;
  localparam logic [4:0] OP_SRL   = 5'b01111;
  localparam logic [4:0] OP_SRA   = 5'b10000;
  localparam logic [4:0] OP_ADDR  = 5'b11000;
  localparam logic [4:0] OP_PASSB = 5'b11001;
  localparam logic [4:0] OP_AUIPC = 5'b11010;
  localparam logic [4:0] OP_JAL   = 5'b11011;

  state_t           r_state;
  logic [4:0]       r_op;
  logic             r_uns;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_work;
  logic [4:0]       r_count;
  logic [WIDTH-1:0] r_result;
  logic             r_valid;
  logic             r_busy;
  logic             r_zero;

  logic             w_is_shift_in;
  logic             w_lt;
  logic [WIDTH-1:0] w_exec_result;
  logic [WIDTH-1:0] w_shift_step;

  assign w_is_shift_in = (bus.alu_op == OP_SLL) || (bus.alu_op == OP_SRL) ||
                         (bus.alu_op == OP_SRA);

  assign w_lt = r_uns ? (r_a < r_b) : ($signed(r_a) < $signed(r_b));

  always_comb begin
    w_exec_result = '0;
    case (r_op)
      OP_ADD, OP_ADDR, OP_AUIPC, OP_JAL: w_exec_result = r_a + r_b;
      OP_SUB:   w_exec_result = r_a - r_b;
      OP_SLT:   w_exec_result = {{(WIDTH-1){1'b0}}, w_lt};
      OP_AND:   w_exec_result = r_a & r_b;
      OP_OR:    w_exec_result = r_a | r_b;
      OP_XOR:   w_exec_result = r_a ^ r_b;
      // Shifts only reach EXEC with a zero shift amount.
      OP_SLL, OP_SRL, OP_SRA: w_exec_result = r_a;
      OP_PASSB: w_exec_result = r_b;
      default:  w_exec_result = '0;
    endcase
  end

  always_comb begin
    w_shift_step = r_work;
    case (r_op)
      OP_SLL:  w_shift_step = {r_work[WIDTH-2:0], 1'b0};
      OP_SRL:  w_shift_step = {1'b0, r_work[WIDTH-1:1]};
      OP_SRA:  w_shift_step = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
      default: w_shift_step = r_work;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_uns    <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_work   <= '0;
      r_count  <= '0;
      r_result <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_valid <= 1'b0;
          if (bus.alu_en) begin
            r_op   <= bus.alu_op;
            r_uns  <= bus.op_unsigned;
            r_a    <= bus.op_a;
            r_b    <= bus.op_b;
            r_busy <= 1'b1;
            if (w_is_shift_in && (bus.op_b[4:0] != 5'd0)) begin
              r_work  <= bus.op_a;
              r_count <= bus.op_b[4:0];
              r_state <= S_SHIFT;
            end else begin
              r_state <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          if (!bus.alu_en) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_result <= w_exec_result;
            r_zero   <= (w_exec_result == '0);
            r_valid  <= 1'b1;
            r_state  <= S_HOLD;
          end
        end
        S_SHIFT: begin
          if (!bus.alu_en) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_count <= '0;
          end else begin
            r_work  <= w_shift_step;
            r_count <= r_count - 5'd1;
            // Last step: publish the shifted value in the same edge.
            if (r_count == 5'd1) begin
              r_result <= w_shift_step;
              r_zero   <= (w_shift_step == '0);
              r_valid  <= 1'b1;
              r_state  <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          r_valid <= 1'b0;
          // A request still held high here is the one just served.
          if (!bus.alu_en) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.alu_result = r_result;
  assign bus.alu_valid  = r_valid;
  assign bus.alu_busy   = r_busy;
  assign bus.alu_zero   = r_zero;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  logic        clk;
  logic        rst;
  logic [1:0]  dbg_state;

  alu_seq_if #(.WIDTH(32)) bus ();

  alu_seq #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;

  logic        chk_on;
  logic        exp_valid;
  logic        exp_busy;
  logic [31:0] exp_result;
  logic        exp_zero;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // One compare process: outputs are checked against the model every cycle.
  always @(negedge clk) begin
    if (chk_on) begin
      check("valid",  {31'd0, bus.alu_valid}, {31'd0, exp_valid});
      check("busy",   {31'd0, bus.alu_busy},  {31'd0, exp_busy});
      check("result", bus.alu_result, exp_result);
      check("zero",   {31'd0, bus.alu_zero},  {31'd0, exp_zero});
    end
  end

  // ---------------- behavioural model ----------------
  function automatic logic [31:0] model_alu(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic uns);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      5'b00001, 5'b11000, 5'b11010, 5'b11011: return a + b;
      5'b00011: return a - b;
      5'b00101: begin
        if (uns) return (a < b) ? 32'd1 : 32'd0;
        else     return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      end
      5'b01010: return a & b;
      5'b01100: return a | b;
      5'b01101: return a ^ b;
      5'b01110: return a << sh;
      5'b01111: return a >> sh;
      5'b10000: return $unsigned($signed(a) >>> sh);
      5'b11001: return b;
      default:  return 32'd0;
    endcase
  endfunction

  function automatic int model_latency(input logic [4:0] op, input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    if ((op == 5'b01110 || op == 5'b01111 || op == 5'b10000) && sh != 5'd0)
      return 1 + int'(sh);
    return 2;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_inputs();
    bus.op_a        = $urandom;
    bus.op_b        = $urandom;
    bus.alu_op      = 5'($urandom_range(0, 31));
    bus.op_unsigned = 1'($urandom_range(0, 1));
  endtask

  // Full transaction: accept, wait for the single valid pulse, keep alu_en
  // high for `hold` extra cycles, then release.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic uns, input int hold);
    int          lat;
    logic [31:0] res;
    lat = model_latency(op, b);
    res = model_alu(op, a, b, uns);
    bus.alu_op = op; bus.op_a = a; bus.op_b = b; bus.op_unsigned = uns;
    bus.alu_en = 1'b1;
    for (int k = 1; k <= lat; k++) begin
      tick();
      if (k == 1) scramble_inputs();
      exp_busy = 1'b1;
      if (k == lat) begin
        exp_valid  = 1'b1;
        exp_result = res;
        exp_zero   = (res == 32'd0);
      end else begin
        exp_valid = 1'b0;
      end
    end
    for (int h = 0; h < hold; h++) begin
      tick();
      exp_valid = 1'b0;
      exp_busy  = 1'b1;
    end
    bus.alu_en = 1'b0;
    tick();
    exp_valid = 1'b0;
    exp_busy  = 1'b0;
  endtask

  // Accept, stay busy for k more edges, then drop alu_en before completion.
  task automatic run_abort(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic uns, input int k);
    bus.alu_op = op; bus.op_a = a; bus.op_b = b; bus.op_unsigned = uns;
    bus.alu_en = 1'b1;
    for (int j = 0; j <= k; j++) begin
      tick();
      exp_busy  = 1'b1;
      exp_valid = 1'b0;
    end
    bus.alu_en = 1'b0;
    tick();
    exp_busy  = 1'b0;
    exp_valid = 1'b0;
  endtask

  // Accept, run k more edges, then reset in the middle of the operation.
  task automatic run_reset(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic uns, input int k);
    bus.alu_op = op; bus.op_a = a; bus.op_b = b; bus.op_unsigned = uns;
    bus.alu_en = 1'b1;
    for (int j = 0; j <= k; j++) begin
      tick();
      exp_busy  = 1'b1;
      exp_valid = 1'b0;
    end
    rst = 1'b1;
    tick();
    exp_busy = 1'b0; exp_valid = 1'b0; exp_result = 32'd0; exp_zero = 1'b0;
    bus.alu_en = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  // ---------------- stimulus ----------------
  logic [4:0] op_list [13];

  initial begin
    op_list = '{5'b00001, 5'b00011, 5'b00101, 5'b01010, 5'b01100, 5'b01101, 5'b01110,
                5'b01111, 5'b10000, 5'b11000, 5'b11001, 5'b11010, 5'b11011};
    chk_on = 1'b0;
    rst = 1'b1;
    bus.alu_en = 1'b0; bus.alu_op = '0; bus.op_unsigned = 1'b0;
    bus.op_a = '0; bus.op_b = '0;
    exp_valid = 1'b0; exp_busy = 1'b0; exp_result = 32'd0; exp_zero = 1'b0;

    // Pin the model with hand-computed values.
    check("model_add_wrap", model_alu(5'b00001, 32'h7FFFFFFF, 32'd1, 1'b0), 32'h80000000);
    check("model_slt_s",    model_alu(5'b00101, 32'hFFFFFFFF, 32'd1, 1'b0), 32'd1);
    check("model_sltu",     model_alu(5'b00101, 32'hFFFFFFFF, 32'd1, 1'b1), 32'd0);
    check("model_sra31",    model_alu(5'b10000, 32'h80000000, 32'd31, 1'b0), 32'hFFFFFFFF);
    check("model_lat_sra31", 32'(model_latency(5'b10000, 32'd31)), 32'd32);

    tick(); tick();
    chk_on = 1'b1;          // reset state checked by the compare process
    tick();
    rst = 1'b0;
    tick();

    // 1: ADD wrap, 2-edge latency
    run_op(5'b00001, 32'h7FFFFFFF, 32'd1, 1'b0, 0);
    check("t1_add", bus.alu_result, 32'h80000000);
    // 2: SUB to zero, SLT signed / unsigned
    run_op(5'b00011, 32'd5, 32'd5, 1'b0, 0);
    check("t2_sub_zero", {31'd0, bus.alu_zero}, 32'd1);
    run_op(5'b00101, 32'hFFFFFFFF, 32'd1, 1'b0, 0);
    check("t2_slt", bus.alu_result, 32'd1);
    run_op(5'b00101, 32'hFFFFFFFF, 32'd1, 1'b1, 0);
    check("t2_sltu", bus.alu_result, 32'd0);
    // 3: SRA by 31, SLL by 0 (upper op_b bits must not matter)
    run_op(5'b10000, 32'h80000000, 32'd31, 1'b0, 0);
    check("t3_sra31", bus.alu_result, 32'hFFFFFFFF);
    run_op(5'b01110, 32'h00001234, 32'h00000020, 1'b0, 0);
    check("t3_sll0", bus.alu_result, 32'h00001234);
    // 4: alu_en held 3 cycles past valid
    run_op(5'b01100, 32'h00F0, 32'h0F00, 1'b0, 3);
    check("t4_or", bus.alu_result, 32'h00000FF0);
    // 5: SRL aborted after 3 shift cycles, old result kept
    run_abort(5'b01111, 32'hF0000000, 32'd8, 1'b0, 3);
    check("t5_kept", bus.alu_result, 32'h00000FF0);
    check("t5_idle", {30'd0, dbg_state}, 32'd0);
    // EXEC abort
    run_abort(5'b00001, 32'd1, 32'd2, 1'b0, 0);
    // 6: reset mid-shift, then unknown op
    run_reset(5'b01110, 32'h1, 32'd20, 1'b0, 4);
    check("t6_rst_result", bus.alu_result, 32'd0);
    run_op(5'b11001, 32'd0, 32'hABCD0000, 1'b0, 0);
    run_op(5'b10101, 32'd7, 32'd9, 1'b0, 1);
    check("t6_unknown", bus.alu_result, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 80; n++) begin
      logic [4:0]  op;
      logic [31:0] a, b;
      int          mode;
      op   = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31))
                                         : op_list[$urandom_range(0, 12)];
      a    = $urandom;
      b    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      if ($urandom_range(0, 5) == 0) a = b;
      mode = $urandom_range(0, 9);
      if (mode == 0)
        run_abort(op, a, b, 1'($urandom_range(0, 1)),
                  $urandom_range(0, model_latency(op, b) - 2));
      else
        run_op(op, a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) tick();
    end

    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
